// File: rtl/alarm_pkg.sv
// Shared definitions for the four-slot calendar alarm: slot count, packed BCD
// timestamp layout and a helper that assembles a timestamp from its fields.
package alarm_pkg;

  localparam int unsigned NUM_ALARMS = 4;
  localparam int unsigned TS_W       = 56;

  localparam int unsigned SEC_LSB   = 0;
  localparam int unsigned MIN_LSB   = 8;
  localparam int unsigned HOUR_LSB  = 16;
  localparam int unsigned DAY_LSB   = 24;
  localparam int unsigned MONTH_LSB = 32;
  localparam int unsigned YEAR_LSB  = 40;

  typedef logic [TS_W-1:0] ts_t;

  function automatic ts_t pack_ts(input logic [15:0] year, input logic [7:0] month,
                                  input logic [7:0] day, input logic [7:0] hour,
                                  input logic [7:0] minute, input logic [7:0] second);
    return {year, month, day, hour, minute, second};
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored timestamp, armed flag, comparator and match history.
// hit_o pulses combinationally on the first cycle the running time matches.
module alarm_slot
  import alarm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_i,
  input  ts_t  wr_ts_i,
  input  ts_t  now_i,
  output ts_t  ts_o,
  output logic hit_o
);

  ts_t  ts_q, ts_d;
  logic armed_q, armed_d;
  logic match_q;
  logic match;

  always_comb begin
    ts_d    = ts_q;
    armed_d = armed_q;
    if (wr_i) begin
      ts_d    = wr_ts_i;
      armed_d = 1'b1;
    end
  end

  assign match = armed_q && (now_i == ts_q);
  // Edge-detect so a time that stays equal rings only once.
  assign hit_o = match && !match_q;
  assign ts_o  = ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q    <= '0;
      armed_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      armed_q <= armed_d;
      match_q <= match;
    end
  end

endmodule

// File: rtl/alarm.sv
// Four-slot calendar alarm: programs slots from a shared bus, latches a ring on
// the first match of any armed slot, and shows the selected slot's time of day.
module alarm
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [15:0] alarm_year_bcd_in,
  input  logic [7:0]  alarm_month_bcd_in,
  input  logic [7:0]  alarm_day_bcd_in,
  input  logic [7:0]  alarm_hour_bcd_in,
  input  logic [7:0]  alarm_minute_bcd_in,
  input  logic [7:0]  alarm_second_bcd_in,
  input  logic [1:0]  selected_alarm,
  input  logic [63:0] counter,
  input  logic        cancel,
  output logic [7:0]  alarm_hour_bcd,
  output logic [7:0]  alarm_minute_bcd,
  output logic [7:0]  alarm_second_bcd,
  output logic        ring
);

  ts_t                  wr_ts;
  ts_t                  now;
  ts_t                  slot_ts [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] hits;
  logic                 ring_q, ring_d;
  logic                 unused_counter_hi;

  assign wr_ts = pack_ts(alarm_year_bcd_in, alarm_month_bcd_in, alarm_day_bcd_in,
                         alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in);
  assign now   = counter[TS_W-1:0];
  assign unused_counter_hi = ^counter[63:TS_W];

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot u_slot (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .wr_i    (set && (selected_alarm == 2'(i))),
      .wr_ts_i (wr_ts),
      .now_i   (now),
      .ts_o    (slot_ts[i]),
      .hit_o   (hits[i])
    );
  end

  // A fresh hit wins over a simultaneous cancel.
  always_comb begin
    ring_d = ring_q;
    if (|hits) begin
      ring_d = 1'b1;
    end else if (cancel) begin
      ring_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ring_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring             = ring_q;
  assign alarm_hour_bcd   = slot_ts[selected_alarm][HOUR_LSB +: 8];
  assign alarm_minute_bcd = slot_ts[selected_alarm][MIN_LSB +: 8];
  assign alarm_second_bcd = slot_ts[selected_alarm][SEC_LSB +: 8];

endmodule

// File: tb/tb_alarm.sv
// Scoreboard bench for alarm: stimulus pushes the expected post-edge state,
// a negedge monitor pops and compares ring and the display fields.
module tb_alarm;

  logic        clk;
  logic        rst_n;
  logic        set;
  logic [15:0] yr;
  logic [7:0]  mo, dy, hr, mi, se;
  logic [1:0]  sel;
  logic [63:0] counter;
  logic        cancel;
  logic [7:0]  o_hr, o_mi, o_se;
  logic        ring;

  typedef struct {
    string      name;
    bit         ring;
    bit         chk_disp;
    logic [7:0] hr;
    logic [7:0] mi;
    logic [7:0] se;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] T1 = {8'h00, 16'h2023, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
  localparam logic [63:0] T2 = {8'h00, 16'h2024, 8'h02, 8'h29, 8'h12, 8'h34, 8'h56};

  alarm dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .set                 (set),
    .alarm_year_bcd_in   (yr),
    .alarm_month_bcd_in  (mo),
    .alarm_day_bcd_in    (dy),
    .alarm_hour_bcd_in   (hr),
    .alarm_minute_bcd_in (mi),
    .alarm_second_bcd_in (se),
    .selected_alarm      (sel),
    .counter             (counter),
    .cancel              (cancel),
    .alarm_hour_bcd      (o_hr),
    .alarm_minute_bcd    (o_mi),
    .alarm_second_bcd    (o_se),
    .ring                (ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: state after each edge is sampled on the following falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (ring !== cur.ring) begin
        errors++;
        $display("FAIL %s: ring got %0b want %0b", cur.name, ring, cur.ring);
      end
      if (cur.chk_disp) begin
        checks++;
        if ({o_hr, o_mi, o_se} !== {cur.hr, cur.mi, cur.se}) begin
          errors++;
          $display("FAIL %s: display got %h:%h:%h want %h:%h:%h", cur.name,
                   o_hr, o_mi, o_se, cur.hr, cur.mi, cur.se);
        end
      end
    end
  end

  // Apply the current inputs at the next edge and queue the resulting state.
  task automatic tick(input string name, input bit exp_ring, input bit chk,
                      input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_t e;
    @(posedge clk);
    e.name = name; e.ring = exp_ring; e.chk_disp = chk; e.hr = h; e.mi = m; e.se = s;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic tick_r(input string name, input bit exp_ring);
    tick(name, exp_ring, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic load(input logic [63:0] t);
    yr = t[55:40]; mo = t[39:32]; dy = t[31:24];
    hr = t[23:16]; mi = t[15:8];  se = t[7:0];
  endtask

  initial begin
    @(negedge clk);
    #1;
    // Reset with junk on every input.
    rst_n = 1'b1; set = 1'b1; cancel = 1'b1; sel = 2'd0; counter = 64'hFFFF_0000_1234_5678;
    load(T2);
    tick("reset", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b0; set = 1'b0; cancel = 1'b0; counter = '0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick($sformatf("reset_disp_sel%0d", i), 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    end

    // Program slot 0 and read it back.
    sel = 2'd0; load(T1); set = 1'b1;
    tick("prog0", 1'b0, 1'b1, 8'h23, 8'h59, 8'h59);
    set = 1'b0; load(64'h0); sel = 2'd1;
    tick("sel1_empty", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    sel = 2'd0;
    tick("sel0_back", 1'b0, 1'b1, 8'h23, 8'h59, 8'h59);

    for (int i = 0; i < 100; i++) begin
      counter = 64'(i);
      tick_r("nomatch", 1'b0);
    end

    // Trigger, hold, and persistence after counter moves on.
    counter = T1;
    tick_r("trigger", 1'b1);
    tick_r("hold_static", 1'b1);
    counter = 64'd5;
    tick_r("hold_moved", 1'b1);

    // Cancel while still matching: no re-fire.
    counter = T1;
    tick_r("rematch_while_ringing", 1'b1);
    cancel = 1'b1;
    tick_r("cancel", 1'b0);
    cancel = 1'b0;
    tick_r("no_refire1", 1'b0);
    tick_r("no_refire2", 1'b0);
    counter = 64'd7;
    tick_r("away", 1'b0);
    counter = T1;
    tick_r("retrigger", 1'b1);

    // Upper counter byte is ignored.
    counter = {8'hFF, T1[55:0]};
    cancel = 1'b1;
    tick_r("cancel_hi_byte", 1'b0);
    cancel = 1'b0; counter = '0;
    tick_r("idle", 1'b0);
    counter = {8'hA5, T1[55:0]};
    tick_r("trigger_hi_byte", 1'b1);
    cancel = 1'b1; counter = '0;
    tick_r("cancel2", 1'b0);
    cancel = 1'b0;

    // Slot 2: hit coincident with cancel keeps ring set.
    sel = 2'd2; load(T2); set = 1'b1;
    tick("prog2", 1'b0, 1'b1, 8'h12, 8'h34, 8'h56);
    set = 1'b0;
    counter = T2; cancel = 1'b1;
    tick_r("hit_beats_cancel", 1'b1);
    cancel = 1'b0;
    tick_r("hit_beats_cancel_hold", 1'b1);
    cancel = 1'b1;
    tick_r("cancel3", 1'b0);
    cancel = 1'b0; counter = '0;
    tick_r("zero_vs_unarmed", 1'b0);

    // Write while ringing leaves ring alone.
    counter = T1;
    tick_r("trigger_again", 1'b1);
    sel = 2'd3; load({8'h00, 16'h1999, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03}); set = 1'b1;
    tick("write_while_ring", 1'b1, 1'b1, 8'h01, 8'h02, 8'h03);
    set = 1'b0;

    // Reset mid-ring disarms everything.
    rst_n = 1'b1;
    tick("reset_mid_ring", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b0; counter = '0;
    tick_r("post_reset_idle", 1'b0);
    counter = T1; sel = 2'd0;
    tick("post_reset_disarmed", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    tick_r("post_reset_disarmed2", 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
